// File: rtl/ast_arb_pkg.sv
// ----------------------------------------------------------------------------
// ast_arb_pkg
// Shared types and helpers for the packet-level round-robin Avalon-ST arbiter.
//   state_t : arbiter FSM state (IDLE = free to pick, LOCK = packet in flight)
//   idx_w() : width of an index able to address n inputs (minimum 1 bit)
// ----------------------------------------------------------------------------
package ast_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ast_rr_packet_arb_if.sv
// ----------------------------------------------------------------------------
// ast_rr_packet_arb_if
// Bundles the IN_DIRS_CNT Avalon-ST sink streams and the merged Avalon-ST
// source stream of the packet arbiter.
//   ast_sink_*   : per-input data/valid/ready/empty/startofpacket/endofpacket
//   ast_source_* : merged data/valid/ready/empty/startofpacket/endofpacket
// Modports:
//   slave  : the arbiter's view (consumes sinks, produces the source)
//   master : the surrounding logic's view (produces sinks, consumes source)
// ----------------------------------------------------------------------------
interface ast_rr_packet_arb_if #(
    parameter int BYTE_W      = 8,
    parameter int IN_DIRS_CNT = 4,
    parameter int AST_SYMBOLS = 1,
    parameter int AST_EMPTY_W = (AST_SYMBOLS == 1) ? 1 : $clog2(AST_SYMBOLS)
);

    logic [IN_DIRS_CNT-1:0][AST_SYMBOLS-1:0][BYTE_W-1:0] ast_sink_data_i;
    logic [IN_DIRS_CNT-1:0]                              ast_sink_valid_i;
    logic [IN_DIRS_CNT-1:0]                              ast_sink_ready_o;
    logic [IN_DIRS_CNT-1:0][AST_EMPTY_W-1:0]             ast_sink_empty_i;
    logic [IN_DIRS_CNT-1:0]                              ast_sink_startofpacket_i;
    logic [IN_DIRS_CNT-1:0]                              ast_sink_endofpacket_i;

    logic [AST_SYMBOLS-1:0][BYTE_W-1:0]                  ast_source_data_o;
    logic                                                ast_source_ready_i;
    logic                                                ast_source_valid_o;
    logic [AST_EMPTY_W-1:0]                              ast_source_empty_o;
    logic                                                ast_source_startofpacket_o;
    logic                                                ast_source_endofpacket_o;

    modport slave (
        input  ast_sink_data_i, ast_sink_valid_i, ast_sink_empty_i,
               ast_sink_startofpacket_i, ast_sink_endofpacket_i,
               ast_source_ready_i,
        output ast_sink_ready_o,
               ast_source_data_o, ast_source_valid_o, ast_source_empty_o,
               ast_source_startofpacket_o, ast_source_endofpacket_o
    );

    modport master (
        output ast_sink_data_i, ast_sink_valid_i, ast_sink_empty_i,
               ast_sink_startofpacket_i, ast_sink_endofpacket_i,
               ast_source_ready_i,
        input  ast_sink_ready_o,
               ast_source_data_o, ast_source_valid_o, ast_source_empty_o,
               ast_source_startofpacket_o, ast_source_endofpacket_o
    );

endinterface

// File: rtl/rr_arb_pick.sv
// ----------------------------------------------------------------------------
// rr_arb_pick
// Combinational round-robin picker. Returns the first requester found when
// searching last_idx+1, last_idx+2, ... modulo N.
//   req      : request vector, one bit per input
//   last_idx : index served most recently (lowest priority this round)
//   pick_idx : selected index (meaningful only when pick_vld)
//   pick_vld : at least one request is present
// ----------------------------------------------------------------------------
module rr_arb_pick
    import ast_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_vld
);

    logic [IDX_W:0]   start;
    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [IDX_W:0]   off;
    logic [IDX_W:0]   sum;

    // Duplicating req makes the rotate a plain right shift: bit k of rot is
    // input (start + k) mod N. The lowest set bit of rot is the winner.
    always_comb begin
        start = {1'b0, last_idx} + (IDX_W+1)'(1);
        dbl   = {req, req} >> start;
        rot   = dbl[N-1:0];
        off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = (IDX_W+1)'(k);
            end
        end
        // start <= N and off <= N-1, so a single conditional subtract wraps.
        sum = start + off;
        if (sum >= (IDX_W+1)'(N)) begin
            sum = sum - (IDX_W+1)'(N);
        end
        pick_idx = sum[IDX_W-1:0];
        pick_vld = |req;
    end

endmodule

// File: rtl/ast_rr_packet_arb.sv
// ----------------------------------------------------------------------------
// ast_rr_packet_arb
// Packet-level round-robin arbiter merging IN_DIRS_CNT Avalon-ST sinks into one
// registered Avalon-ST source. A grant is held from SOP to EOP so packets never
// interleave; back-to-back packets from different inputs flow without bubbles.
//   clk_i       : clock
//   rst_i       : asynchronous active-high reset
//   bus         : sink and source streams (slave modport)
//   grant_idx_o : input that supplied the beat currently on the source
//   proto_err_o : one-cycle pulse alongside a beat with bad framing
//                 (SOP=0 when starting a packet, SOP=1 inside a packet)
// ----------------------------------------------------------------------------
module ast_rr_packet_arb
    import ast_arb_pkg::*;
#(
    parameter int BYTE_W      = 8,
    parameter int IN_DIRS_CNT = 4,
    parameter int AST_SYMBOLS = 1,
    parameter int AST_EMPTY_W = (AST_SYMBOLS == 1) ? 1 : $clog2(AST_SYMBOLS),
    parameter int IDX_W       = idx_w(IN_DIRS_CNT)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ast_rr_packet_arb_if.slave bus,
    output logic [IDX_W-1:0]  grant_idx_o,
    output logic              proto_err_o
);

    state_t                             state;
    state_t                             state_nxt;
    logic [IDX_W-1:0]                   last_idx;
    logic [IDX_W-1:0]                   lock_idx;
    logic [IDX_W-1:0]                   pick_idx;
    logic                               pick_vld;
    logic [IDX_W-1:0]                   cur_idx;
    logic                               cur_vld;
    logic                               pipe_ready;

    logic                               xfer_p0;
    logic [AST_SYMBOLS-1:0][BYTE_W-1:0] data_p0;
    logic [AST_EMPTY_W-1:0]             empty_p0;
    logic                               sop_p0;
    logic                               eop_p0;
    logic                               frame_err_p0;

    logic [AST_SYMBOLS-1:0][BYTE_W-1:0] data_p1;
    logic [AST_EMPTY_W-1:0]             empty_p1;
    logic                               sop_p1;
    logic                               eop_p1;
    logic                               vld_p1;
    logic                               err_p1;
    logic [IDX_W-1:0]                   grant_p1;

    rr_arb_pick #(
        .N     (IN_DIRS_CNT),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (bus.ast_sink_valid_i),
        .last_idx (last_idx),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    assign pipe_ready = !vld_p1 || bus.ast_source_ready_i;

    // ---- stage p0: select the granted sink beat ----
    assign xfer_p0  = bus.ast_sink_valid_i[cur_idx] && bus.ast_sink_ready_o[cur_idx];
    assign data_p0  = bus.ast_sink_data_i[cur_idx];
    assign empty_p0 = bus.ast_sink_empty_i[cur_idx];
    assign sop_p0   = bus.ast_sink_startofpacket_i[cur_idx];
    assign eop_p0   = bus.ast_sink_endofpacket_i[cur_idx];
    // A packet must open with SOP when idle and must not repeat SOP while locked.
    assign frame_err_p0 = (state == IDLE) ? !sop_p0 : sop_p0;

    // FSM state register plus the round-robin bookkeeping it drives.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            last_idx <= IDX_W'(IN_DIRS_CNT - 1);
            lock_idx <= '0;
        end else begin
            state <= state_nxt;
            if (xfer_p0 && eop_p0) begin
                last_idx <= cur_idx;
            end
            if (xfer_p0 && (state == IDLE) && !eop_p0) begin
                lock_idx <= cur_idx;
            end
        end
    end

    // FSM next state: single-beat packets never leave IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (xfer_p0 && !eop_p0) state_nxt = LOCK;
            LOCK: if (xfer_p0 && eop_p0)  state_nxt = IDLE;
        endcase
    end

    // FSM outputs: in LOCK only the locked input may advance, even if it
    // has dropped valid. Ready is forced low while reset is held.
    always_comb begin
        cur_idx              = (state == LOCK) ? lock_idx : pick_idx;
        cur_vld              = (state == LOCK) ? 1'b1 : pick_vld;
        bus.ast_sink_ready_o = '0;
        if (pipe_ready && cur_vld && !rst_i) begin
            bus.ast_sink_ready_o[cur_idx] = 1'b1;
        end
    end

    // ---- stage p1: registered source ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_p1  <= '0;
            empty_p1 <= '0;
            sop_p1   <= 1'b0;
            eop_p1   <= 1'b0;
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            grant_p1 <= '0;
        end else begin
            err_p1 <= xfer_p0 && frame_err_p0;
            if (xfer_p0) begin
                data_p1  <= data_p0;
                empty_p1 <= empty_p0;
                sop_p1   <= sop_p0;
                eop_p1   <= eop_p0;
                grant_p1 <= cur_idx;
                vld_p1   <= 1'b1;
            end else if (bus.ast_source_ready_i) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.ast_source_data_o          = data_p1;
    assign bus.ast_source_empty_o         = empty_p1;
    assign bus.ast_source_startofpacket_o = sop_p1;
    assign bus.ast_source_endofpacket_o   = eop_p1;
    assign bus.ast_source_valid_o         = vld_p1;
    assign grant_idx_o                    = grant_p1;
    assign proto_err_o                    = err_p1;

endmodule

// File: tb/tb_ast_rr_packet_arb.sv
// ----------------------------------------------------------------------------
// tb_ast_rr_packet_arb
// Directed bench for ast_rr_packet_arb (4 inputs, 1 byte per beat). Per-input
// source queues feed the sinks and honour ready; every beat expected on the
// source is queued in arrival order and compared as it is consumed.
// ----------------------------------------------------------------------------
module tb_ast_rr_packet_arb;

    typedef struct {
        logic [7:0] data;
        logic       empty;
        logic       sop;
        logic       eop;
        logic [1:0] grant;
        logic       err;
    } beat_t;

    logic       clk;
    logic       rst;
    logic [1:0] grant_idx;
    logic       proto_err;

    int checks = 0;
    int errors = 0;

    beat_t src_q[4][$];
    beat_t exp_q[$];

    ast_rr_packet_arb_if #(.BYTE_W(8), .IN_DIRS_CNT(4), .AST_SYMBOLS(1)) bus ();

    ast_rr_packet_arb #(
        .BYTE_W      (8),
        .IN_DIRS_CNT (4),
        .AST_SYMBOLS (1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .grant_idx_o (grant_idx),
        .proto_err_o (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int port, input logic [7:0] d, input logic sop,
                        input logic eop, input logic err, input bit expect_out);
        beat_t b;
        b.data  = d;
        b.empty = d[0];
        b.sop   = sop;
        b.eop   = eop;
        b.grant = 2'(port);
        b.err   = err;
        src_q[port].push_back(b);
        if (expect_out) exp_q.push_back(b);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.ast_source_valid_o), 32'd0);
        chk({tag, "_data"},  32'(bus.ast_source_data_o), 32'd0);
        chk({tag, "_sop"},   32'(bus.ast_source_startofpacket_o), 32'd0);
        chk({tag, "_eop"},   32'(bus.ast_source_endofpacket_o), 32'd0);
        chk({tag, "_empty"}, 32'(bus.ast_source_empty_o), 32'd0);
        chk({tag, "_grant"}, 32'(grant_idx), 32'd0);
        chk({tag, "_err"},   32'(proto_err), 32'd0);
        chk({tag, "_sink_ready"}, 32'(bus.ast_sink_ready_o), 32'd0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drained_left"}, 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    // Sink-side driver: a beat leaves its queue once it was seen accepted.
    initial begin
        logic [3:0] acc;
        beat_t      hb;
        bus.ast_sink_data_i          = '0;
        bus.ast_sink_valid_i         = '0;
        bus.ast_sink_empty_i         = '0;
        bus.ast_sink_startofpacket_i = '0;
        bus.ast_sink_endofpacket_i   = '0;
        forever begin
            @(negedge clk);
            acc = bus.ast_sink_valid_i & bus.ast_sink_ready_o;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (rst) src_q[i].delete();
                else if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
                if (src_q[i].size() != 0) begin
                    hb = src_q[i][0];
                    bus.ast_sink_data_i[i][0]       = hb.data;
                    bus.ast_sink_empty_i[i]         = hb.empty;
                    bus.ast_sink_startofpacket_i[i] = hb.sop;
                    bus.ast_sink_endofpacket_i[i]   = hb.eop;
                    bus.ast_sink_valid_i[i]         = 1'b1;
                end else begin
                    bus.ast_sink_valid_i[i] = 1'b0;
                end
            end
        end
    end

    // Source-side monitor: compares consumed beats against the scoreboard and
    // expects proto_err only on the first cycle a flagged beat is presented.
    initial begin
        logic  held_prev;
        beat_t h;
        held_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ast_source_valid_o) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_beat observed data %0h expected no beat",
                           bus.ast_source_data_o);
                end
                if (exp_q.size() != 0) begin
                    h = exp_q[0];
                    chk("proto_err", 32'(proto_err), held_prev ? 32'd0 : 32'(h.err));
                    if (bus.ast_source_ready_i) begin
                        chk("beat_data",  32'(bus.ast_source_data_o), 32'(h.data));
                        chk("beat_empty", 32'(bus.ast_source_empty_o), 32'(h.empty));
                        chk("beat_sop",   32'(bus.ast_source_startofpacket_o), 32'(h.sop));
                        chk("beat_eop",   32'(bus.ast_source_endofpacket_o), 32'(h.eop));
                        chk("beat_grant", 32'(grant_idx), 32'(h.grant));
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("proto_err_idle", 32'(proto_err), 32'd0);
            end
            held_prev = bus.ast_source_valid_o && !bus.ast_source_ready_i;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.ast_source_ready_i = 1'b1;
        @(negedge clk);
        chk_zero("in_reset");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("after_reset");
        tick();

        // Round robin over inputs 0..2 with single-beat packets.
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < 3; p++)
                send(p, 8'hA0 + 8'(p), 1'b1, 1'b1, 1'b0, 1'b1);
        n = 0;
        while (!bus.ast_source_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rr_first_valid", 32'(bus.ast_source_valid_o), 32'd1);
        for (int k = 1; k < 9; k++) begin
            @(negedge clk);
            chk("rr_no_bubble", 32'(bus.ast_source_valid_o), 32'd1);
        end
        drain("rr");

        // Packet lock: input 0 must wait for input 2's EOP.
        send(2, 8'h21, 1'b1, 1'b0, 1'b0, 1'b1);
        send(2, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
        send(2, 8'h23, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        send(0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("lock_ready_beat1", 32'(bus.ast_sink_ready_o), 32'h4);
        tick();
        @(negedge clk);
        chk("lock_ready_beat2", 32'(bus.ast_sink_ready_o), 32'h4);
        tick();
        @(negedge clk);
        chk("lock_ready_eop", 32'(bus.ast_sink_ready_o), 32'h4);
        tick();
        @(negedge clk);
        chk("lock_ready_next", 32'(bus.ast_sink_ready_o), 32'h1);
        drain("lock");

        // Backpressure for 5 cycles in the middle of a 6-beat packet.
        for (int k = 0; k < 6; k++)
            send(1, 8'h31 + 8'(k), k == 0, k == 5, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        bus.ast_source_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k != 0) tick();
            @(negedge clk);
            chk("bp_valid", 32'(bus.ast_source_valid_o), 32'd1);
            chk("bp_data",  32'(bus.ast_source_data_o), 32'h32);
            chk("bp_sop",   32'(bus.ast_source_startofpacket_o), 32'd0);
            chk("bp_eop",   32'(bus.ast_source_endofpacket_o), 32'd0);
            chk("bp_grant", 32'(grant_idx), 32'd1);
            chk("bp_sink_ready", 32'(bus.ast_sink_ready_o), 32'd0);
        end
        tick();
        bus.ast_source_ready_i = 1'b1;
        drain("bp");

        // Framing errors: missing SOP in IDLE, repeated SOP in LOCK.
        send(3, 8'h3E, 1'b0, 1'b1, 1'b1, 1'b1);
        send(3, 8'h40, 1'b1, 1'b0, 1'b0, 1'b1);
        send(3, 8'h41, 1'b1, 1'b1, 1'b1, 1'b1);
        drain("frame");

        // Reset in the middle of a locked 4-beat packet.
        send(2, 8'h51, 1'b1, 1'b0, 1'b0, 1'b1);
        send(2, 8'h52, 1'b0, 1'b0, 1'b0, 1'b0);
        send(2, 8'h53, 1'b0, 1'b0, 1'b0, 1'b0);
        send(2, 8'h54, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        #1;
        rst = 1'b1;
        #1;
        chk_zero("async_reset");
        tick();
        tick();
        rst = 1'b0;
        send(1, 8'h61, 1'b1, 1'b0, 1'b0, 1'b1);
        send(1, 8'h62, 1'b0, 1'b1, 1'b0, 1'b1);
        send(3, 8'h70, 1'b1, 1'b1, 1'b0, 1'b1);
        drain("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ast_rr_packet_arb.md
# ast_rr_packet_arb

Packet-level round-robin arbiter that merges `IN_DIRS_CNT` Avalon-ST sink streams into one Avalon-ST source. A grant is held from start-of-packet to end-of-packet, so packets are never interleaved. It sits between the per-window/per-length `data_to_ast` converters and the downstream string consumer, in the source clock domain, as the fair alternative to a one-hot mux. The output is registered and sustains one beat per cycle, including back-to-back packets from different inputs.

## Interface
- `BYTE_W`, 8, symbol width in bits.
- `IN_DIRS_CNT`, 4, number of sink streams (≥1).
- `AST_SYMBOLS`, 1, symbols per beat.
- `AST_EMPTY_W`, `(AST_SYMBOLS==1) ? 1 : $clog2(AST_SYMBOLS)`, width of the empty field.
- `IDX_W`, `(IN_DIRS_CNT==1) ? 1 : $clog2(IN_DIRS_CNT)`, width of the grant index.

Ports:
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `ast_sink_data_i`  in  `[IN_DIRS_CNT-1:0][AST_SYMBOLS-1:0][BYTE_W-1:0]`  per-input beat data.
- `ast_sink_valid_i`  in  `[IN_DIRS_CNT-1:0]`  per-input valid.
- `ast_sink_ready_o`  out  `[IN_DIRS_CNT-1:0]`  per-input ready.
- `ast_sink_empty_i`  in  `[IN_DIRS_CNT-1:0][AST_EMPTY_W-1:0]`  per-input empty.
- `ast_sink_startofpacket_i`  in  `[IN_DIRS_CNT-1:0]`  per-input SOP.
- `ast_sink_endofpacket_i`  in  `[IN_DIRS_CNT-1:0]`  per-input EOP.
- `ast_source_data_o`  out  `[AST_SYMBOLS-1:0][BYTE_W-1:0]`  merged data.
- `ast_source_ready_i`  in  1  downstream ready.
- `ast_source_valid_o`  out  1  merged valid.
- `ast_source_empty_o`  out  `AST_EMPTY_W`  merged empty.
- `ast_source_startofpacket_o`  out  1  merged SOP.
- `ast_source_endofpacket_o`  out  1  merged EOP.
- `grant_idx_o`  out  `IDX_W`  index of the input that supplied the current output beat.
- `proto_err_o`  out  1  one-cycle pulse on a framing error.

## Operation
- **Pipeline ready:** `pipe_ready = !ast_source_valid_o || ast_source_ready_i`.
- **Sink ready:** `ast_sink_ready_o[i] = pipe_ready && (i == cur_idx)`, combinational. All other inputs see ready 0.
- **Transfer:** on input `i`, a transfer is `ast_sink_valid_i[i] && ast_sink_ready_o[i]`.
- **FSM states:** IDLE, LOCK.
- **IDLE:**
  - `cur_idx` = first input with valid set, searching `last_idx+1, last_idx+2, …` modulo `IN_DIRS_CNT`.
  - If no input is valid, `ast_sink_ready_o` is all zero.
  - Transfer with EOP: stay in IDLE, `last_idx <= cur_idx`.
  - Transfer without EOP: go to LOCK, `lock_idx <= cur_idx`.
- **LOCK:**
  - `cur_idx = lock_idx`. No other input is considered.
  - Transfer with EOP: go to IDLE, `last_idx <= lock_idx`.
- **Output register:** on a transfer, latch data, empty, SOP, EOP and `grant_idx_o`, and set valid.
  - If `ast_source_ready_i` and there is no transfer, valid clears.
  - While valid && !`ast_source_ready_i`, all output fields hold stable.
- **Framing errors:** `proto_err_o` pulses one cycle after the accepted beat when either:
  - a beat accepted in IDLE has SOP=0, or
  - a beat accepted in LOCK has SOP=1.
  - The beat is still forwarded unmodified; FSM transitions are unchanged.
- **Fairness:** an input is served at most `IN_DIRS_CNT-1` packets after it first asserts valid in IDLE.

## Timing
- **Reset values:** all outputs 0, state IDLE, `last_idx = IN_DIRS_CNT-1` (input 0 has first priority), `lock_idx = 0`.
- **Latency:** input transfer to `ast_source_valid_o` is 1 cycle.
- **Throughput:** 1 beat/cycle. No bubble between packets, even when the next packet comes from a different input.
- **Simultaneous events:** if an EOP transfer on input `i` occurs while input `j` is valid, input `j` is granted in the next cycle (IDLE evaluation with `last_idx = i`).
- **Single-beat packets** (SOP=EOP=1) never enter LOCK.
- **Valid deassertion:** a locked input may drop valid mid-packet. The arbiter stays in LOCK and inserts idle cycles.
- **Reset mid-packet:** outputs clear asynchronously. The partial packet is abandoned; downstream must tolerate a missing EOP.
- **`IN_DIRS_CNT=1`:** the arbiter degenerates to a registered pass-through with framing check.

## Structure
- **Package `ast_arb_pkg`:** holds `state_t` enum {IDLE, LOCK} and the `IDX_W` helper function.
- **Sub-module `rr_arb_pick`:** combinational, parameter `N`. Inputs are `req[N-1:0]` and `last_idx`; outputs are `pick_idx` and `pick_vld`. It uses a double-width rotate-and-priority-encode.

## Test plan
- **Reset:** assert `rst_i` asynchronously mid-cycle → all outputs 0 immediately. After release with all valid low, `ast_sink_ready_o = 4'b0000`.
- **Round-robin:** `IN_DIRS_CNT=4`; inputs 0, 1, 2 each hold continuous single-beat packets (data `0xA0+i`), ready tied high → output sequence `A0, A1, A2, A0, …` on consecutive cycles, `grant_idx_o = 0, 1, 2, 0`.
- **Packet lock:** input 2 sends a 3-beat packet (`0x21`, `0x22`, `0x23`) while input 0 is valid from the second beat → output `21, 22, 23` then `0x00`. Input 0's ready stays 0 until the cycle of input 2's EOP transfer.
- **Backpressure:** `ast_source_ready_i=0` for 5 cycles in mid-packet → output fields stable, all sink ready 0, no beat lost or duplicated after release.
- **Framing error:** a beat with SOP=0 arrives in IDLE on input 3 → forwarded, `proto_err_o=1` for exactly one cycle coincident with its output valid.
- **Reset mid-lock:** reset asserted during a 4-beat packet after beat 2 → state IDLE. A new packet on input 1 is granted first-come after release.
